// File: rtl/frog_game_ctrl.sv
// Frog game control: per-frame collision test of the frog against five cars,
// lives/score bookkeeping and the NEWGAME/INGAME/NEWLIFE/DONE state machine.
module frog_game_ctrl #(
    parameter int FROG_HALF      = 10,
    parameter int CAR_LEN        = 50,
    parameter int LANE_Y0        = 30,
    parameter int LANE_Y1        = 80,
    parameter int LANE_Y2        = 140,
    parameter int LANE_Y3        = 200,
    parameter int LANE_Y4        = 300,
    parameter int LANE_H         = 20,
    parameter int GOAL_Y         = 20,
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 30,
    parameter int WIN_SCORE      = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        ack,
    input  logic [9:0]  frog_x,
    input  logic [9:0]  frog_y,
    input  logic [49:0] car_x,
    output logic [3:0]  state,
    output logic [1:0]  lives,
    output logic [3:0]  score,
    output logic        hit,
    output logic        respawn,
    output logic        win
);

    typedef enum logic [3:0] {
        NEWGAME = 4'b0001,
        INGAME  = 4'b0010,
        NEWLIFE = 4'b0100,
        DONE    = 4'b1000
    } state_t;

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [10:0]      HALF      = 11'(FROG_HALF);
    localparam logic [10:0]      CLEN      = 11'(CAR_LEN);
    localparam logic [10:0]      LHEIGHT   = 11'(LANE_H);
    localparam logic [10:0]      GOAL      = 11'(GOAL_Y);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0]       SCORE_MAX = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);

    state_t           cur_state;
    logic [CNT_W-1:0] frame_cnt;

    logic [10:0] fx_lo, fx_hi, fy_lo, fy_hi;
    logic        collide;
    logic        at_goal;

    function automatic logic [10:0] lane_y(input int n);
        case (n)
            0:       return 11'(LANE_Y0);
            1:       return 11'(LANE_Y1);
            2:       return 11'(LANE_Y2);
            3:       return 11'(LANE_Y3);
            default: return 11'(LANE_Y4);
        endcase
    endfunction

    assign state = cur_state;

    // Frog bounding box in 11-bit unsigned; lower edges clamp at 0 instead of wrapping.
    always_comb begin
        fx_hi = {1'b0, frog_x} + HALF;
        fy_hi = {1'b0, frog_y} + HALF;
        fx_lo = ({1'b0, frog_x} < HALF) ? 11'd0 : {1'b0, frog_x} - HALF;
        fy_lo = ({1'b0, frog_y} < HALF) ? 11'd0 : {1'b0, frog_y} - HALF;
    end

    // Closed-interval overlap test of the frog box against each car, ORed over lanes.
    always_comb begin
        logic [10:0] car;
        logic [10:0] ly;
        // NOTE: every variable assigned here gets a default first, so no path leaves it
        // holding its old value and no latch is inferred.
        collide = 1'b0;
        car     = '0;
        ly      = '0;
        for (int n = 0; n < 5; n++) begin
            car = {1'b0, car_x[10*n +: 10]};
            ly  = lane_y(n);
            if ((fy_hi >= ly) && (fy_lo <= ly + LHEIGHT) &&
                (fx_hi >= car) && (fx_lo <= car + CLEN))
                collide = 1'b1;
        end
    end

    assign at_goal = ({1'b0, frog_y} <= GOAL);

    // Game state machine with registered outputs; all game changes happen on frame ticks.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            cur_state <= NEWGAME;
            lives     <= LIVES_INIT;
            score     <= '0;
            hit       <= 1'b0;
            respawn   <= 1'b0;
            win       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            hit     <= 1'b0;
            respawn <= 1'b0;
            case (cur_state)
                NEWGAME: begin
                    lives <= LIVES_INIT;
                    score <= '0;
                    win   <= 1'b0;
                    if (frame_tick && start) begin
                        cur_state <= INGAME;
                        respawn   <= 1'b1;
                    end
                end
                INGAME: begin
                    if (frame_tick) begin
                        if (collide) begin
                            // Collision beats the goal check; score is left alone.
                            hit <= 1'b1;
                            if (lives <= 2'd1) begin
                                lives     <= 2'd0;
                                win       <= 1'b0;
                                cur_state <= DONE;
                            end else begin
                                lives     <= lives - 2'd1;
                                frame_cnt <= '0;
                                cur_state <= NEWLIFE;
                            end
                        end else if (at_goal && (score < SCORE_MAX)) begin
                            score   <= score + 4'd1;
                            respawn <= 1'b1;
                            if (score + 4'd1 == SCORE_MAX) begin
                                win       <= 1'b1;
                                cur_state <= DONE;
                            end
                        end
                    end
                end
                NEWLIFE: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            respawn   <= 1'b1;
                            cur_state <= INGAME;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (frame_tick && ack)
                        cur_state <= NEWGAME;
                end
                default: cur_state <= NEWGAME;
            endcase
        end
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed self-checking bench for frog_game_ctrl.
module tb_frog_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        start;
    logic        ack;
    logic [9:0]  frog_x;
    logic [9:0]  frog_y;
    logic [49:0] car_x;
    logic [3:0]  state;
    logic [1:0]  lives;
    logic [3:0]  score;
    logic        hit;
    logic        respawn;
    logic        win;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [49:0] CARS_FAR = {5{10'd1000}};

    frog_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .ack        (ack),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .car_x      (car_x),
        .state      (state),
        .lives      (lives),
        .score      (score),
        .hit        (hit),
        .respawn    (respawn),
        .win        (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle frame tick; returns 1 time unit after the edge that sampled it.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        ack        = 1'b0;
        frog_x     = 10'd100;
        frog_y     = 10'd400;
        car_x      = CARS_FAR;
        idle();
        idle();
        check("rst_state", state, 4'b0001);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_hit", hit, 0);
        check("rst_respawn", respawn, 0);
        check("rst_win", win, 0);
        @(negedge clk);
        reset = 1'b0;

        // Start a game
        idle();
        check("ng_hold", state, 4'b0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", state, 4'b0010);
        check("start_respawn", respawn, 1);
        check("start_lives", lives, 3);
        check("start_score", score, 0);
        idle();
        check("start_respawn_clr", respawn, 0);

        // Collision in lane 0, then 30 frames in NEWLIFE with collisions ignored
        frog_x = 10'd100;
        frog_y = 10'd40;
        car_x  = {CARS_FAR[49:10], 10'd80};
        tick();
        check("c1_hit", hit, 1);
        check("c1_lives", lives, 2);
        check("c1_state", state, 4'b0100);
        idle();
        check("c1_hit_clr", hit, 0);
        ticks(29);
        check("nl29_state", state, 4'b0100);
        check("nl29_respawn", respawn, 0);
        check("nl29_lives", lives, 2);
        tick();
        check("nl30_respawn", respawn, 1);
        check("nl30_state", state, 4'b0010);

        // x boundary: right edge 79 misses a car at 80, 80 touches it
        frog_x = 10'd69;
        tick();
        check("x69_hit", hit, 0);
        check("x69_state", state, 4'b0010);
        frog_x = 10'd70;
        tick();
        check("x70_hit", hit, 1);
        check("x70_lives", lives, 1);
        ticks(30);
        check("nl_back", state, 4'b0010);

        // x clamp: frog_x=5 gives left edge 0, overlapping a car at 0 -> last life lost
        frog_x = 10'd5;
        car_x  = {CARS_FAR[49:10], 10'd0};
        tick();
        check("clamp_hit", hit, 1);
        check("last_lives", lives, 0);
        check("last_state", state, 4'b1000);
        check("last_win", win, 0);

        // DONE ignores start, leaves on ack
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_ign", state, 4'b1000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_state", state, 4'b0001);
        idle();
        check("ng_lives", lives, 3);

        // New game, score to WIN_SCORE
        frog_x = 10'd100;
        frog_y = 10'd400;
        car_x  = CARS_FAR;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        // y clamp: frog_y=9 spans 0..19, above lane 0 even with a car at x overlap
        frog_y = 10'd9;
        car_x  = {CARS_FAR[49:10], 10'd80};
        tick();
        check("y9_hit", hit, 0);
        check("y9_score", score, 1);
        check("y9_respawn", respawn, 1);
        frog_y = 10'd20;
        car_x  = CARS_FAR;
        for (int s = 2; s <= 9; s++) begin
            tick();
            check($sformatf("goal_score_%0d", s), score, s);
            check($sformatf("goal_respawn_%0d", s), respawn, 1);
            if (s < 9) check($sformatf("goal_state_%0d", s), state, 4'b0010);
        end
        check("win_state", state, 4'b1000);
        check("win_flag", win, 1);
        tick();
        check("win_hold_score", score, 9);
        check("win_hold_state", state, 4'b1000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        idle();
        check("win_ng_score", score, 0);
        check("win_ng_win", win, 0);

        // Goal and collision together: collision wins
        start = 1'b1;
        tick();
        start  = 1'b0;
        frog_x = 10'd100;
        frog_y = 10'd20;
        car_x  = {CARS_FAR[49:10], 10'd80};
        tick();
        check("both_hit", hit, 1);
        check("both_score", score, 0);
        check("both_respawn", respawn, 0);
        check("both_state", state, 4'b0100);
        check("both_lives", lives, 2);

        // Reset mid-NEWLIFE, coinciding with a tick
        ticks(5);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check("mid_rst_state", state, 4'b0001);
        check("mid_rst_lives", lives, 3);
        check("mid_rst_score", score, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_respawn", respawn, 0);
        check("mid_rst_win", win, 0);
        @(negedge clk);
        reset = 1'b0;

        // Frame counter was cleared by reset: a fresh NEWLIFE still lasts 30 ticks
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("post_rst_hit", hit, 1);
        ticks(29);
        check("post_rst_nl29", state, 4'b0100);
        tick();
        check("post_rst_nl30", state, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
